// File: rtl/spi_frame_sequencer.sv
// spi_frame_sequencer
// Captures a counter snapshot on each frame request and sends it to the
// byte-level SPI master as a hi/lo byte pair, framed by slave select.
// A one-deep pending slot holds a request that arrives while a frame is in
// progress. o_overrun counts pending values that were overwritten, saturating at 255.
// Optional feature macro: SPI_FRAME_CHECKSUM_EN appends a third byte (hi XOR lo).
module spi_frame_sequencer #(
    parameter int DATA_W       = 14,
    parameter int SS_SETUP_CYC = 4,
    parameter int SS_HOLD_CYC  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_start,
    output logic [7:0]        o_tx_data,
    input  logic              i_done,
    output logic              o_ss,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic [7:0]        o_overrun
);

`ifdef SPI_FRAME_CHECKSUM_EN
    localparam logic [1:0] LAST_IDX = 2'd2;
`else
    localparam logic [1:0] LAST_IDX = 2'd1;
`endif

    localparam logic [7:0] SETUP_LAST = 8'(SS_SETUP_CYC - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(SS_HOLD_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        START_B,
        WAIT_B,
        HOLD
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [7:0]        r_cnt;
    logic [7:0]        w_nextCnt;
    logic [1:0]        r_idx;
    logic [1:0]        w_nextIdx;
    logic              w_launch;
    logic [DATA_W-1:0] r_shadow;
    logic [DATA_W-1:0] r_pendData;
    logic              r_pending;
    logic [7:0]        r_overrun;
    logic [15:0]       w_padded;
    logic [7:0]        w_hiByte;
    logic [7:0]        w_loByte;

    // Zero-pad the captured word to 16 bits and split it into hi/lo bytes.
    assign w_padded = 16'(r_shadow);
    assign w_hiByte = w_padded[15:8];
    assign w_loByte = w_padded[7:0];

    assign o_busy    = (r_state != IDLE);
    assign o_overrun = r_overrun;

    // FSM state, gap counter and byte index registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_idx   <= 2'd0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            r_idx   <= w_nextIdx;
        end
    end

    // Next-state logic and frame control outputs. Slave select is decoded from
    // state so that it rises in the final HOLD cycle together with o_frame_done.
    always_comb begin
        w_nextState  = r_state;
        w_nextCnt    = r_cnt;
        w_nextIdx    = r_idx;
        w_launch     = 1'b0;
        o_start      = 1'b0;
        o_ss         = 1'b1;
        o_frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req || r_pending) begin
                    w_launch    = 1'b1;
                    w_nextState = SETUP;
                    w_nextCnt   = 8'd0;
                    w_nextIdx   = 2'd0;
                end
            end
            SETUP: begin
                o_ss = 1'b0;
                if (r_cnt == SETUP_LAST) begin
                    w_nextState = START_B;
                    w_nextCnt   = 8'd0;
                end else begin
                    w_nextCnt = r_cnt + 8'd1;
                end
            end
            START_B: begin
                o_ss        = 1'b0;
                o_start     = 1'b1;
                w_nextState = WAIT_B;
            end
            WAIT_B: begin
                o_ss = 1'b0;
                if (i_done) begin
                    if (r_idx == LAST_IDX) begin
                        w_nextState = HOLD;
                        w_nextCnt   = 8'd0;
                    end else begin
                        w_nextIdx   = r_idx + 2'd1;
                        w_nextState = START_B;
                    end
                end
            end
            HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    o_frame_done = 1'b1;
                    w_nextState  = IDLE;
                    w_nextCnt    = 8'd0;
                end else begin
                    o_ss      = 1'b0;
                    w_nextCnt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Shadow register: loaded only when a frame launches; a fresh request
    // wins over the pending value, so bytes never change within a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow <= '0;
        end else if (w_launch) begin
            r_shadow <= i_req ? i_data : r_pendData;
        end
    end

    // One-deep pending slot for requests that arrive while busy, with a
    // saturating count of pending values that got overwritten.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pendData <= '0;
            r_pending  <= 1'b0;
            r_overrun  <= 8'd0;
        end else if (i_req && (r_state != IDLE)) begin
            r_pendData <= i_data;
            r_pending  <= 1'b1;
            if (r_pending && (r_overrun != 8'hFF)) begin
                r_overrun <= r_overrun + 8'd1;
            end
        end else if (w_launch) begin
            r_pending <= 1'b0;
        end
    end

    // Byte selection for the SPI master, driven from the frozen shadow word.
    always_comb begin
        o_tx_data = 8'h00;
        case (r_idx)
            2'd0: o_tx_data = w_hiByte;
            2'd1: o_tx_data = w_loByte;
`ifdef SPI_FRAME_CHECKSUM_EN
            2'd2: o_tx_data = w_hiByte ^ w_loByte;
`endif
            default: o_tx_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// tb_spi_frame_sequencer
// Directed bench for spi_frame_sequencer. Expected bytes are queued when a
// request is issued, and a monitor compares them on every o_start. A simple
// SPI master model answers each o_start with i_done 80 cycles later.
// Honours SPI_FRAME_CHECKSUM_EN by expecting the extra checksum byte.
module tb_spi_frame_sequencer;

    localparam int DONE_DELAY = 80;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [13:0] dataIn;
    logic        start;
    logic [7:0]  txData;
    logic        done;
    logic        ss;
    logic        busy;
    logic        frameDone;
    logic [7:0]  overrun;

    logic        respDone  = 1'b0;
    logic        forceDone = 1'b0;

    int          cycle         = 0;
    int          vectors       = 0;
    int          miscompares   = 0;
    int          startCount    = 0;
    int          respCount     = 0;
    int          lastDoneCycle = 0;
    int          reqCycle      = 0;
    int          tEvent        = 0;
    int          baseStarts    = 0;
    int          waitCnt       = 0;
    logic [7:0]  expByte;
    logic [7:0]  expQ[$];

    assign done = respDone | forceDone;

    spi_frame_sequencer #(
        .DATA_W      (14),
        .SS_SETUP_CYC(4),
        .SS_HOLD_CYC (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_req       (req),
        .i_data      (dataIn),
        .o_start     (start),
        .o_tx_data   (txData),
        .i_done      (done),
        .o_ss        (ss),
        .o_busy      (busy),
        .o_frame_done(frameDone),
        .o_overrun   (overrun)
    );

    // 100 MHz clock and a cycle counter used for latency measurements.
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Queue the bytes a frame carrying d is expected to send.
    function automatic void pushFrame(input logic [13:0] d);
        logic [15:0] p;
        p = {2'b00, d};
        expQ.push_back(p[15:8]);
        expQ.push_back(p[7:0]);
`ifdef SPI_FRAME_CHECKSUM_EN
        expQ.push_back(p[15:8] ^ p[7:0]);
`endif
    endfunction

    // Must be called at a negedge; pulses i_req for one cycle.
    task automatic applyStimulus(input logic [13:0] d, input bit expectSent);
        req    = 1'b1;
        dataIn = d;
        if (expectSent) pushFrame(d);
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic waitStart(output int t);
        int n;
        n = 0;
        while (start !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (start !== 1'b1) checkOutput("startTimeout", 0, 1);
        t = cycle;
    endtask

    task automatic waitFrameDone(output int t);
        int n;
        n = 0;
        while (frameDone !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (frameDone !== 1'b1) checkOutput("frameDoneTimeout", 0, 1);
        t = cycle;
    endtask

    // SPI master model: answers each o_start with a one-cycle i_done.
    initial begin
        forever begin
            @(negedge clk);
            respDone = 1'b0;
            if (reset) begin
                respCount = 0;
            end else begin
                if (respCount > 0) begin
                    respCount--;
                    if (respCount == 0) begin
                        respDone      = 1'b1;
                        lastDoneCycle = cycle;
                    end
                end
                if (start === 1'b1) respCount = DONE_DELAY;
            end
        end
    end

    // Monitor: compares each transmitted byte against the scoreboard queue.
    initial begin
        forever begin
            @(negedge clk);
            if (start === 1'b1) begin
                startCount++;
                checkOutput("ssLowAtStart", ss, 0);
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedStart", 1, 0);
                end else begin
                    expByte = expQ.pop_front();
                    checkOutput("txByte", txData, expByte);
                end
            end
            if (frameDone === 1'b1) checkOutput("ssHighAtFrameDone", ss, 1);
        end
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached, vectors=%0d", vectors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        reset  = 1'b1;
        req    = 1'b0;
        dataIn = 14'h0;
        repeat (3) @(negedge clk);
        checkOutput("rstStart", start, 0);
        checkOutput("rstTxData", txData, 0);
        checkOutput("rstSs", ss, 1);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstFrameDone", frameDone, 0);
        checkOutput("rstOverrun", overrun, 0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] basic frame 0x1A5C and timing");
        reqCycle = cycle;
        applyStimulus(14'h1A5C, 1'b1);
        checkOutput("ssLowAfterReq", ss, 0);
        checkOutput("busyAfterReq", busy, 1);
        waitStart(tEvent);
        checkOutput("firstStartLatency", tEvent - reqCycle, 5);
        waitFrameDone(tEvent);
        checkOutput("ssRiseAfterLastDone", tEvent - lastDoneCycle, 4);
        @(negedge clk);
        checkOutput("busyAfterFrame", busy, 0);
        checkOutput("ssIdleAfterFrame", ss, 1);

        $display("[TB] overrun with three mid-frame requests");
        applyStimulus(14'h0123, 1'b1);
        repeat (10) @(negedge clk);
        applyStimulus(14'h0001, 1'b0);
        @(negedge clk);
        applyStimulus(14'h0002, 1'b0);
        @(negedge clk);
        applyStimulus(14'h0003, 1'b1);
        waitFrameDone(tEvent);
        checkOutput("overrunCount", overrun, 2);
        @(negedge clk);
        checkOutput("gapSsHigh", ss, 1);
        checkOutput("gapBusyLow", busy, 0);
        @(negedge clk);
        checkOutput("pendingLaunched", busy, 1);
        waitFrameDone(tEvent);

        $display("[TB] request coincident with frame done");
        @(negedge clk);
        applyStimulus(14'h0055, 1'b1);
        waitFrameDone(tEvent);
        applyStimulus(14'h3FFF, 1'b1);
        checkOutput("coincidentGapSs", ss, 1);
        checkOutput("overrunAfterCoincident", overrun, 2);
        waitFrameDone(tEvent);
        checkOutput("overrunUnchanged", overrun, 2);

        $display("[TB] reset during second byte");
        @(negedge clk);
        baseStarts = startCount;
        applyStimulus(14'h0AAA, 1'b0);
        expQ.push_back(8'h0A);
        expQ.push_back(8'hAA);
        waitCnt = 0;
        while (startCount < baseStarts + 2 && waitCnt < 1000) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("secondByteStarted", startCount - baseStarts, 2);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("midResetSs", ss, 1);
        checkOutput("midResetStart", start, 0);
        checkOutput("midResetBusy", busy, 0);
        checkOutput("midResetOverrun", overrun, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] spurious i_done in IDLE and SETUP");
        baseStarts = startCount;
        forceDone  = 1'b1;
        @(negedge clk);
        forceDone = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("idleDoneNoStart", startCount - baseStarts, 0);
        checkOutput("idleDoneBusy", busy, 0);
        reqCycle = cycle;
        applyStimulus(14'h2345, 1'b1);
        forceDone = 1'b1;
        @(negedge clk);
        forceDone = 1'b0;
        waitStart(tEvent);
        checkOutput("setupDoneLatency", tEvent - reqCycle, 5);
        waitFrameDone(tEvent);
        @(negedge clk);
        checkOutput("queueDrained", expQ.size(), 0);
        checkOutput("finalBusy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_frame_sequencer.md
Name: spi_frame_sequencer

Overview:
- Sequences the SPI master datapath so it sends one counter snapshot per frame request.
- Latches the 14-bit counter value on a request tick and splits it into bytes.
- Issues one start pulse per byte to the byte-level SPI master and waits for its done pulse.
- Drives slave select around the whole frame with setup/hold gaps. Sits between the counter/tick logic and the SPI master inside master_top.

Parameters:
- DATA_W, 14, width of captured data word; fixed two-byte frame, upper byte zero-padded.
- SS_SETUP_CYC, 4, clk cycles between ss falling and first o_start (range 1..255).
- SS_HOLD_CYC, 4, clk cycles between last byte done and ss rising (range 1..255).

Ports:
- clk  input  1  system clock (100 MHz).
- reset  input  1  asynchronous, active-high reset.
- i_req  input  1  single-cycle frame request (counter tick).
- i_data  input  DATA_W  value to send; sampled only when i_req=1.
- o_start  output  1  single-cycle pulse to the SPI master: begin byte transfer.
- o_tx_data  output  8  byte to the SPI master; stable from o_start until i_done.
- i_done  input  1  single-cycle pulse from the SPI master: byte complete.
- o_ss  output  1  slave select, active low.
- o_busy  output  1  high while a frame is in progress (any state except IDLE).
- o_frame_done  output  1  single-cycle pulse when ss returns high at frame end.
- o_overrun  output  8  saturating count of pending requests overwritten before service.

Behaviour:
- Reset values (async, immediate): o_start=0, o_tx_data=0, o_ss=1, o_busy=0, o_frame_done=0, o_overrun=0, FSM=IDLE, pending=0.
- Byte format: hi = {(16-DATA_W) zeros, data[DATA_W-1:8]}, lo = data[7:0]. Hi byte is sent first.
- FSM states: IDLE, SETUP, START_B, WAIT_B, HOLD.
  - IDLE: if pending=1 or i_req=1, load the shadow register (the i_req value has priority over the pending value), clear pending, set byte index=0, ss=0, go to SETUP.
  - SETUP: count SS_SETUP_CYC cycles, then go to START_B.
  - START_B: drive o_tx_data = byte[index], pulse o_start for one cycle, go to WAIT_B.
  - WAIT_B: on i_done, if index is the last byte go to HOLD; otherwise increment index and go to START_B. The next o_start therefore comes exactly 1 cycle after i_done.
  - HOLD: count SS_HOLD_CYC cycles, then set ss=1, pulse o_frame_done in that same cycle, go to IDLE.
- Latency: i_req in IDLE at cycle N gives ss low at N+1 and first o_start at N+1+SS_SETUP_CYC.
- i_req while busy: capture i_data into a one-deep pending slot and set pending.
  - If pending is already 1: overwrite the value and increment o_overrun, saturating at 255.
- i_req in the same cycle as o_frame_done: treated as busy, so it goes to pending. The new frame starts the cycle after FSM enters IDLE, giving at least one idle cycle with ss=1 between frames.
- i_done outside WAIT_B is ignored.
- The shadow register is never modified mid-frame, so o_tx_data stays consistent within a frame.
- Reset mid-frame: ss goes high immediately, pending and partial frame are discarded, o_overrun is cleared.

Optional Feature:
- SPI_FRAME_CHECKSUM_EN
  - Defined: frame is 3 bytes (hi, lo, hi XOR lo). The checksum is sent as a third START_B/WAIT_B pair before HOLD.
  - Undefined: frame is 2 bytes. No checksum logic is present.

Test Plan:
- Reset, i_req with i_data=14'h1A5C, SPI model answering i_done 80 cycles after each o_start → bytes 0x1A then 0x5C, ss low from req+1. With the macro, a third byte 0x46 follows.
- Check timing with defaults → first o_start 5 cycles after i_req. ss rises 4 cycles after the last i_done, with o_frame_done in that cycle. o_busy=0 the next cycle.
- Three i_req mid-frame with values 0x0001, 0x0002, 0x0003 → o_overrun=2. The next frame sends 0x00, 0x03 and starts after at least one ss-high cycle.
- i_req coincident with o_frame_done (data 0x3FFF) → second frame sends 0x3F, 0xFF. No request is lost and o_overrun stays unchanged.
- Assert reset during WAIT_B of byte 1 → o_ss=1 and o_start=0 immediately. After release, the FSM is idle and an i_done pulse is ignored.
- Spurious i_done in IDLE/SETUP → no state change and no o_start generated.
